// File: rtl/exec_pkg.sv
// exec_stage shared definitions: ALU codes, funct values,
// control bit indices, forward selects and bus field offsets.
package exec_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;

  localparam int C_REGWRITE = 0;
  localparam int C_ALUSRC   = 1;
  localparam int C_MEMREAD  = 2;
  localparam int C_ALUOP    = 3;
  localparam int C_MEMTOREG = 5;
  localparam int C_MEMWRITE = 6;
  localparam int C_REGDST   = 7;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_WB = 2'b01,
    FWD_EX = 2'b10
  } fwd_e;

  // idex word slots, in units of DATA_W
  localparam int IDEX_INSTR = 0;
  localparam int IDEX_RD1   = 1;
  localparam int IDEX_RD2   = 2;
  localparam int IDEX_IMM   = 3;
  localparam int IDEX_CTRL  = 4;

  // memwb fields above the DATA_W result
  localparam int WB_RD       = 0;
  localparam int WB_REGWRITE = 5;

  // exmem fields above the 2*DATA_W data words
  localparam int EXM_WREG     = 0;
  localparam int EXM_ZERO     = 5;
  localparam int EXM_OVF      = 6;
  localparam int EXM_MEMREAD  = 7;
  localparam int EXM_MEMTOREG = 8;
  localparam int EXM_MEMWRITE = 9;
  localparam int EXM_REGWRITE = 10;

  function automatic fwd_e fwd_select(
    input logic       ex_rw,
    input logic [4:0] ex_rd,
    input logic       wb_rw,
    input logic [4:0] wb_rd,
    input logic [4:0] src
  );
    fwd_e sel;
    sel = FWD_RF;
    if (ex_rw && ex_rd != 5'd0 && ex_rd == src)
      sel = FWD_EX;
    else if (wb_rw && wb_rd != 5'd0 && wb_rd == src)
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/exec_if.sv
// exec_stage pipeline buses: ID/EX and MEM/WB in,
// registered EX/MEM out.
interface exec_if #(
  parameter int DATA_W = 32
);
  logic [4*DATA_W+7:0]  idex;
  logic [DATA_W+5:0]    memwb;
  logic [2*DATA_W+10:0] exmem;

  modport master (
    output idex,
    output memwb,
    input  exmem
  );

  modport slave (
    input  idex,
    input  memwb,
    output exmem
  );
endinterface

// File: rtl/exec_alu.sv
// exec_stage ALU: wrap-around arithmetic, logic, SLT
// and rt-operand shifts with ADD/SUB signed overflow.
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        code,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              zero
);
  localparam int W = DATA_W;

  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic         slt;

  assign sum  = a + b;
  assign diff = a - b;
  assign slt  = $signed(a) < $signed(b);

  always_comb begin
    result = sum;
    ovf    = 1'b0;
    case (code)
      ALU_ADD: begin
        result = sum;
        ovf = (a[W-1] == b[W-1]) &&
              (sum[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        result = diff;
        ovf = (a[W-1] != b[W-1]) &&
              (diff[W-1] != a[W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {{(W-1){1'b0}}, slt};
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      default: result = sum;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exec_stage.sv
// MIPS execute stage with registered EX/MEM bus.
// Define EXEC_FORWARDING_EN to enable EX/MEM + MEM/WB forwarding.
module exec_stage
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic   clk,
  input logic   rst_n,
  exec_if.slave bus
);
  localparam int W = DATA_W;

  logic [7:0]   ctrl;
  logic [W-1:0] imm;
  logic [W-1:0] rd1;
  logic [W-1:0] rd2;
  logic [5:0]   funct;
  logic [4:0]   shamt;
  logic [4:0]   rd;
  logic [4:0]   rt;
  logic [4:0]   rs;
  logic [1:0]   aluop;

  assign ctrl  = bus.idex[IDEX_CTRL*W +: 8];
  assign imm   = bus.idex[IDEX_IMM*W +: W];
  assign rd2   = bus.idex[IDEX_RD2*W +: W];
  assign rd1   = bus.idex[IDEX_RD1*W +: W];
  assign funct = bus.idex[5:0];
  assign shamt = bus.idex[10:6];
  assign rd    = bus.idex[15:11];
  assign rt    = bus.idex[20:16];
  assign rs    = bus.idex[25:21];
  assign aluop = ctrl[C_ALUOP +: 2];

  logic unused_opcode;
  assign unused_opcode = ^bus.idex[W-1:26];

  logic [2*W+10:0] exmem_q;
  logic            ex_regwrite;
  logic [4:0]      ex_wreg;
  logic [W-1:0]    ex_result;
  logic            wb_regwrite;
  logic [4:0]      wb_rd;
  logic [W-1:0]    wb_result;

  assign ex_regwrite = exmem_q[2*W+EXM_REGWRITE];
  assign ex_wreg     = exmem_q[2*W+EXM_WREG +: 5];
  assign ex_result   = exmem_q[W-1:0];
  assign wb_regwrite = bus.memwb[W+WB_REGWRITE];
  assign wb_rd       = bus.memwb[W+WB_RD +: 5];
  assign wb_result   = bus.memwb[W-1:0];

  logic [3:0] alu_code;

  always_comb begin
    alu_code = ALU_ADD;
    unique case (aluop)
      2'b00: alu_code = ALU_ADD;
      2'b01: alu_code = ALU_SUB;
      2'b11: alu_code = ALU_ADD;
      2'b10: begin
        case (funct)
          F_ADD:   alu_code = ALU_ADD;
          F_SUB:   alu_code = ALU_SUB;
          F_AND:   alu_code = ALU_AND;
          F_OR:    alu_code = ALU_OR;
          F_NOR:   alu_code = ALU_NOR;
          F_SLT:   alu_code = ALU_SLT;
          F_SLL:   alu_code = ALU_SLL;
          F_SRL:   alu_code = ALU_SRL;
          default: alu_code = ALU_ADD;
        endcase
      end
      default: alu_code = ALU_ADD;
    endcase
  end

  fwd_e fwd_a;
  fwd_e fwd_b;

`ifdef EXEC_FORWARDING_EN
  // compares against our own registered EX/MEM word
  assign fwd_a = fwd_select(ex_regwrite, ex_wreg,
                            wb_regwrite, wb_rd, rs);
  assign fwd_b = fwd_select(ex_regwrite, ex_wreg,
                            wb_regwrite, wb_rd, rt);
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;

  logic unused_fwd;
  assign unused_fwd = ^{ex_regwrite, ex_wreg,
                        wb_regwrite, wb_rd, rs};
`endif

  logic [W-1:0] op_a;
  logic [W-1:0] fwd_b_val;
  logic [W-1:0] op_b;

  always_comb begin
    op_a = rd1;
    case (fwd_a)
      FWD_WB:  op_a = wb_result;
      FWD_EX:  op_a = ex_result;
      default: op_a = rd1;
    endcase
  end

  always_comb begin
    fwd_b_val = rd2;
    case (fwd_b)
      FWD_WB:  fwd_b_val = wb_result;
      FWD_EX:  fwd_b_val = ex_result;
      default: fwd_b_val = rd2;
    endcase
  end

  assign op_b = ctrl[C_ALUSRC] ? imm : fwd_b_val;

  logic [W-1:0] result;
  logic         ovf;
  logic         zero;
  logic [4:0]   wreg;

  exec_alu #(
    .DATA_W (W)
  ) u_alu (
    .a      (op_a),
    .b      (op_b),
    .code   (alu_code),
    .shamt  (shamt),
    .result (result),
    .ovf    (ovf),
    .zero   (zero)
  );

  assign wreg = ctrl[C_REGDST] ? rd : rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= {ctrl[C_REGWRITE],
                  ctrl[C_MEMWRITE],
                  ctrl[C_MEMTOREG],
                  ctrl[C_MEMREAD],
                  ovf,
                  zero,
                  wreg,
                  fwd_b_val,
                  result};
    end
  end

  assign bus.exmem = exmem_q;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: forwarding, ALU ops,
// flags, immediate path and asynchronous reset.
module tb_exec_stage;

`ifdef EXEC_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  exec_if #(.DATA_W(32)) bus ();

  exec_stage #(
    .DATA_W (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic [7:0]  ctrl,
    input logic [31:0] instr,
    input logic [31:0] rd1,
    input logic [31:0] rd2,
    input logic [31:0] imm,
    input logic        wrw,
    input logic [4:0]  wrd,
    input logic [31:0] wres
  );
    @(negedge clk);
    bus.idex  = {ctrl, imm, rd2, rd1, instr};
    bus.memwb = {wrw, wrd, wres};
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] res();
    return bus.exmem[31:0];
  endfunction

  function automatic logic [31:0] sdata();
    return bus.exmem[63:32];
  endfunction

  function automatic logic [31:0] wreg();
    return {27'd0, bus.exmem[68:64]};
  endfunction

  function automatic logic [31:0] flag(input int b);
    return {31'd0, bus.exmem[b]};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, ".lo"}, bus.exmem[31:0], 32'd0);
    check({tag, ".mid"}, bus.exmem[63:32], 32'd0);
    check({tag, ".hi"}, {21'd0, bus.exmem[74:64]}, 32'd0);
  endtask

  initial begin
    bus.idex  = '0;
    bus.memwb = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // add $s1,$s2,$s3 with $s2 from MEM/WB
    drive(8'h91, 32'h02538820, 32'd5, 32'd10, 32'd0,
          1'b1, 5'd18, 32'd165);
    check("t1.res", res(), FWD ? 32'd175 : 32'd15);
    check("t1.wreg", wreg(), 32'd17);
    check("t1.rw", flag(74), 32'd1);
    check("t1.ovf", flag(70), 32'd0);
    check("t1.zero", flag(69), 32'd0);

    // add $s3,$s2,$s1: $s1 in both EX/MEM and MEM/WB
    drive(8'h91, 32'h02519820, -32'sd15, 32'd7, 32'd0,
          1'b1, 5'd17, 32'd189);
    check("t2.res", res(), FWD ? 32'd160 : 32'hFFFF_FFF8);
    check("t2.wreg", wreg(), 32'd19);
    check("t2.sdata", sdata(), FWD ? 32'd175 : 32'd7);

    drive(8'h91, 32'h01095020, 32'h7FFF_FFFF, 32'd1, 32'd0,
          1'b0, 5'd0, 32'd0);
    check("add_ovf.res", res(), 32'h8000_0000);
    check("add_ovf.ovf", flag(70), 32'd1);

    // beq-style compare
    drive(8'h08, 32'h01090000, 32'd42, 32'd42, 32'd0,
          1'b0, 5'd0, 32'd0);
    check("sub0.res", res(), 32'd0);
    check("sub0.zero", flag(69), 32'd1);
    check("sub0.ovf", flag(70), 32'd0);
    check("sub0.rw", flag(74), 32'd0);
    check("sub0.wreg", wreg(), 32'd9);

    drive(8'h03, 32'h8E510064, 32'd16, 32'd0, -32'sd16,
          1'b0, 5'd0, 32'd0);
    check("imm.res", res(), 32'd0);
    check("imm.zero", flag(69), 32'd1);
    check("imm.wreg", wreg(), 32'd17);
    check("imm.mr", flag(71), 32'd0);

    // write to $0 must never be forwarded
    drive(8'h91, 32'h01090020, 32'd3, 32'd4, 32'd0,
          1'b0, 5'd0, 32'd0);
    check("r0.res", res(), 32'd7);
    check("r0.wreg", wreg(), 32'd0);
    check("r0.rw", flag(74), 32'd1);

    drive(8'h91, 32'h00005020, 32'd11, 32'd22, 32'd0,
          1'b1, 5'd0, 32'd99);
    check("r0g.res", res(), 32'd33);
    check("r0g.sdata", sdata(), 32'd22);

    drive(8'h91, 32'h00095880, 32'd1234, 32'd9, 32'd0,
          1'b0, 5'd0, 32'd0);
    check("sll.res", res(), 32'd36);
    check("sll.wreg", wreg(), 32'd11);

    drive(8'h91, 32'h00095902, 32'd0, 32'h8000_0000, 32'd0,
          1'b0, 5'd0, 32'd0);
    check("srl.res", res(), 32'h0800_0000);

    drive(8'h91, 32'h0109602A, -32'sd3, 32'd2, 32'd0,
          1'b0, 5'd0, 32'd0);
    check("slt.res", res(), 32'd1);

    drive(8'h91, 32'h01096827, 32'h0F0F_0000, 32'h0000_00FF,
          32'd0, 1'b0, 5'd0, 32'd0);
    check("nor.res", res(), 32'hF0F0_FF00);

    drive(8'h91, 32'h01095022, 32'h8000_0000, 32'd1, 32'd0,
          1'b0, 5'd0, 32'd0);
    check("sub_ovf.res", res(), 32'h7FFF_FFFF);
    check("sub_ovf.ovf", flag(70), 32'd1);

    drive(8'h91, 32'h0109602A, -32'sd3, 32'd2, 32'd0,
          1'b0, 5'd0, 32'd0);
    check("pre_rst.res", res(), 32'd1);

    // reset asserted and released between clock edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("arst");
    @(posedge clk);
    #1;
    check_zero("arst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_zero("arst_rel");
    @(posedge clk);
    #1;
    check("post_rst.res", res(), 32'd1);
    check("post_rst.wreg", wreg(), 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
